// File: rtl/seg_scan_driver_pkg.sv
// Shared types and constants for the 3-digit seven-segment scan driver.
//   conv_state_t   : binary-to-BCD converter FSM states
//   SEG_TABLE      : segment patterns for digits 0..9 (seg[0]=a ... seg[6]=g)
//   SEG_BLANK      : all segments off
//   DIG_*          : one-hot digit enables
//   bcd_adjust()   : double-dabble correction (add 3 to every nibble >= 5)
package seg_scan_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [2:0] DIG_ONES = 3'b001;
    localparam logic [2:0] DIG_TENS = 3'b010;
    localparam logic [2:0] DIG_HUNS = 3'b100;
    localparam logic [2:0] DIG_NONE = 3'b000;

    function automatic logic [11:0] bcd_adjust(input logic [11:0] acc);
        logic [11:0] res;
        res = acc;
        for (int i = 0; i < 3; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_scan_driver_digit_to_seg.sv
// BCD digit to seven-segment decode (combinational).
//   digit : 4-bit BCD digit; codes above 9 decode to all segments off
//   seg   : active-high segments, seg[0]=a ... seg[6]=g
module digit_to_seg
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (digit <= 4'd9) begin
            seg = SEG_TABLE[digit];
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Three-digit multiplexed seven-segment driver with a built-in
// shift-and-add-3 binary-to-BCD converter.
//   clk, rst_n : clock, asynchronous active-low reset
//   value      : 8-bit binary number to display
//   hold       : 1 = keep the displayed number frozen
//   seg        : registered segment drive (active-high)
//   dig_en     : registered one-hot digit enable ([0]=ones)
//   bcd        : displayed number, {hundreds,tens,ones}
//   busy       : 1 while a conversion is in progress
//
// Converter states:
//   state    | meaning
//   ST_IDLE  | sample value, clear accumulator and iteration count
//   ST_SHIFT | one add-3/shift iteration per cycle, 8 iterations
//   ST_DONE  | load accumulator into bcd unless hold, back to idle
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int unsigned SCAN_DIV      = 1024,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  value,
    input  logic        hold,
    output logic [6:0]  seg,
    output logic [2:0]  dig_en,
    output logic [11:0] bcd,
    output logic        busy
);

    localparam logic [15:0] PRE_TC = 16'(SCAN_DIV - 1);

    conv_state_t state_q;
    logic [7:0]  shift_q;
    logic [11:0] acc_q;
    logic [2:0]  iter_q;
    logic [11:0] acc_adj;

    assign acc_adj = bcd_adjust(acc_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            iter_q  <= '0;
            bcd     <= '0;
            busy    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    shift_q <= value;
                    acc_q   <= '0;
                    iter_q  <= '0;
                    busy    <= 1'b1;
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // {acc,shift} <<= 1 after correcting the accumulator
                    acc_q   <= {acc_adj[10:0], shift_q[7]};
                    shift_q <= {shift_q[6:0], 1'b0};
                    iter_q  <= iter_q + 3'd1;
                    if (iter_q == 3'd7) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!hold) begin
                        bcd <= acc_q;
                    end
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    logic [15:0] pre_q;
    logic [1:0]  idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PRE_TC) begin
            pre_q <= '0;
            idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end else begin
            pre_q <= pre_q + 16'd1;
        end
    end

    logic [3:0] nib;
    logic       blank;
    logic [2:0] en_nxt;
    logic [6:0] dec_seg;

    always_comb begin
        nib    = 4'd0;
        blank  = 1'b1;
        en_nxt = DIG_NONE;
        case (idx_q)
            2'd0: begin
                nib    = bcd[3:0];
                blank  = 1'b0;
                en_nxt = DIG_ONES;
            end
            2'd1: begin
                nib    = bcd[7:4];
                blank  = (BLANK_LEADING != 0) && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
                en_nxt = DIG_TENS;
            end
            2'd2: begin
                nib    = bcd[11:8];
                blank  = (BLANK_LEADING != 0) && (bcd[11:8] == 4'd0);
                en_nxt = DIG_HUNS;
            end
            default: begin
                nib    = 4'd0;
                blank  = 1'b1;
                en_nxt = DIG_NONE;
            end
        endcase
    end

    digit_to_seg u_dec (
        .digit (nib),
        .seg   (dec_seg)
    );

    // seg and dig_en share one register stage so they always switch together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg    <= SEG_BLANK;
            dig_en <= DIG_NONE;
        end else begin
            seg    <= blank ? SEG_BLANK : dec_seg;
            dig_en <= en_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [7:0]  value;
    logic        hold;

    logic [6:0]  seg_bl, seg_nb;
    logic [2:0]  dig_en_bl, dig_en_nb;
    logic [11:0] bcd_bl, bcd_nb;
    logic        busy_bl, busy_nb;

    int n_checks = 0;
    int n_fail   = 0;

    seg_scan_driver #(.SCAN_DIV(4), .BLANK_LEADING(1)) dut_bl (
        .clk    (clk),
        .rst_n  (rst_n),
        .value  (value),
        .hold   (hold),
        .seg    (seg_bl),
        .dig_en (dig_en_bl),
        .bcd    (bcd_bl),
        .busy   (busy_bl)
    );

    seg_scan_driver #(.SCAN_DIV(4), .BLANK_LEADING(0)) dut_nb (
        .clk    (clk),
        .rst_n  (rst_n),
        .value  (value),
        .hold   (hold),
        .seg    (seg_nb),
        .dig_en (dig_en_nb),
        .bcd    (bcd_nb),
        .busy   (busy_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] model_seg(input int idx, input logic [11:0] b, input bit bl);
        logic [3:0] h, t, o;
        h = b[11:8];
        t = b[7:4];
        o = b[3:0];
        if (idx == 0) return dec7(o);
        if (idx == 1) return (bl && h == 0 && t == 0) ? 7'h00 : dec7(t);
        return (bl && h == 0) ? 7'h00 : dec7(h);
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    typedef struct {
        logic [6:0]  seg_bl;
        logic [6:0]  seg_nb;
        logic [2:0]  dig_en;
        logic [11:0] bcd;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];

    // reference model: 10-cycle conversion period, 4-cycle digit dwell
    int         m_phase, m_pre, m_idx;
    logic [7:0] m_samp;
    logic [11:0] m_bcd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_pre   = 0;
            m_idx   = 0;
            m_samp  = 0;
            m_bcd   = 0;
            exp_q.delete();
        end else begin
            exp_t e;
            e.dig_en = 3'b001 << m_idx;
            e.seg_bl = model_seg(m_idx, m_bcd, 1'b1);
            e.seg_nb = model_seg(m_idx, m_bcd, 1'b0);
            if (m_phase == 0) m_samp = value;
            else if (m_phase == 9 && !hold) m_bcd = to_bcd(int'(m_samp));
            m_phase = (m_phase == 9) ? 0 : m_phase + 1;
            e.busy = (m_phase != 0);
            e.bcd  = m_bcd;
            if (m_pre == 3) begin
                m_pre = 0;
                m_idx = (m_idx == 2) ? 0 : m_idx + 1;
            end else begin
                m_pre = m_pre + 1;
            end
            exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_seg", {seg_bl, seg_nb}, 0);
            chk("rst_dig_en", {dig_en_bl, dig_en_nb}, 0);
            chk("rst_bcd", {bcd_bl, bcd_nb}, 0);
            chk("rst_busy", {busy_bl, busy_nb}, 0);
        end else if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_seg_bl", seg_bl, e.seg_bl);
            chk("sb_seg_nb", seg_nb, e.seg_nb);
            chk("sb_dig_en_bl", dig_en_bl, e.dig_en);
            chk("sb_dig_en_nb", dig_en_nb, e.dig_en);
            chk("sb_bcd", bcd_bl, e.bcd);
            chk("sb_bcd_nb", bcd_nb, e.bcd);
            chk("sb_busy", busy_bl, e.busy);
            chk("sb_busy_nb", busy_nb, e.busy);
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // leave the bench just after the edge preceding a sample edge
    task automatic align_phase(input int ph);
        bit found;
        found = 0;
        for (int i = 0; i < 12; i++) begin
            edges(1);
            if (m_phase == ph) begin
                found = 1;
                break;
            end
        end
        chk("align", found, 1);
    endtask

    initial begin
        rst_n = 1'b1;
        value = 8'd255;
        hold  = 1'b0;
        #1 rst_n = 1'b0;
        #11;
        chk("reset_seg", seg_bl, 7'h00);
        chk("reset_dig_en", dig_en_bl, 3'b000);
        chk("reset_busy", busy_bl, 1'b0);

        // value 255 from reset release
        @(negedge clk) rst_n = 1'b1;
        edges(1);
        chk("first_dig_en", dig_en_bl, 3'b001);
        chk("first_seg", seg_bl, 7'h3F);
        chk("first_busy", busy_bl, 1'b1);
        edges(8);
        chk("pre_load_bcd", bcd_bl, 12'h000);
        edges(1);
        chk("bcd_255", bcd_bl, 12'h255);
        chk("busy_idle", busy_bl, 1'b0);
        edges(1);
        chk("huns_en", dig_en_bl, 3'b100);
        chk("huns_seg", seg_bl, 7'h5B);
        edges(2);
        chk("ones_en", dig_en_bl, 3'b001);
        chk("ones_seg", seg_bl, 7'h6D);
        edges(4);
        chk("tens_en", dig_en_bl, 3'b010);
        chk("tens_seg", seg_bl, 7'h6D);
        edges(20);

        // value 7: blanking vs. no blanking
        value = 8'd7;
        edges(22);
        chk("bcd_7", bcd_bl, 12'h007);
        edges(12);

        // value 0
        value = 8'd0;
        edges(22);
        chk("bcd_0", bcd_bl, 12'h000);
        edges(12);

        // sample 100, then change value mid-conversion
        align_phase(0);
        value = 8'd100;
        edges(1);
        edges(3);
        value = 8'd42;
        edges(6);
        chk("bcd_100", bcd_bl, 12'h100);
        edges(10);
        chk("bcd_042", bcd_bl, 12'h042);

        // hold freezes bcd while scanning continues
        value = 8'd123;
        edges(22);
        chk("bcd_123", bcd_bl, 12'h123);
        hold  = 1'b1;
        value = 8'd200;
        edges(30);
        chk("hold_bcd", bcd_bl, 12'h123);
        hold = 1'b0;
        edges(10);
        chk("release_bcd", bcd_bl, 12'h200);

        // asynchronous reset mid-SHIFT
        value = 8'd59;
        align_phase(3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_seg", {seg_bl, seg_nb}, 0);
        chk("async_dig_en", {dig_en_bl, dig_en_nb}, 0);
        chk("async_bcd", {bcd_bl, bcd_nb}, 0);
        chk("async_busy", {busy_bl, busy_nb}, 0);
        edges(2);
        @(negedge clk) rst_n = 1'b1;
        edges(1);
        chk("rel_dig_en", dig_en_bl, 3'b001);
        edges(9);
        chk("rel_bcd", bcd_bl, 12'h059);
        edges(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter: SCAN_DIV, default 1024, clock cycles each digit is displayed; legal range 2..65535.
REQ-002 Parameter: BLANK_LEADING, default 1, 1 = suppress leading zeros.
REQ-003 Port: clk  input  1  single clock, all state on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: value  input  8  unsigned binary count from the upstream counter stage.
REQ-006 Port: hold  input  1  1 = freeze the displayed number.
REQ-007 Port: seg  output  7  segments, active-high, seg[0]=a ... seg[6]=g.
REQ-008 Port: dig_en  output  3  one-hot digit enable, active-high; [0]=ones, [1]=tens, [2]=hundreds.
REQ-009 Port: bcd  output  12  displayed number as BCD {hundreds,tens,ones}.
REQ-010 Port: busy  output  1  1 while a conversion is in progress.

Function
REQ-011 The converter FSM SHALL have states IDLE, SHIFT and DONE.
REQ-012 In IDLE the block SHALL capture value into an 8-bit shift register, clear a 12-bit BCD accumulator, clear the iteration count, and go to SHIFT.
REQ-013 In SHIFT the block SHALL, each cycle, add 3 to every BCD nibble >= 5, then shift {accumulator,shift register} left by one; after the 8th iteration it SHALL go to DONE.
REQ-014 In DONE the block SHALL load the accumulator into bcd when hold=0, leave bcd unchanged when hold=1, and return to IDLE.
REQ-015 Conversion period SHALL be fixed at 10 cycles: value sampled at edge N appears on bcd after edge N+9.
REQ-016 Changes on value after the sample edge SHALL not affect that conversion.
REQ-017 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-018 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; at terminal count, a 2-bit digit index SHALL advance 0->1->2->0 (value 3 never occurs).
REQ-019 seg and dig_en SHALL be registered and updated on the same edge from the current index and bcd, so both change together (no ghosting).
REQ-020 dig_en SHALL be 3'b001, 3'b010 or 3'b100 for index 0, 1, 2 respectively.
REQ-021 The decode SHALL be 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex); any nibble >9 SHALL give 00.
REQ-022 When BLANK_LEADING=1, seg SHALL be 00 when showing hundreds if hundreds=0, and when showing tens if hundreds=0 and tens=0.
REQ-023 The ones digit SHALL never be blanked, so value 0 shows 3F on ones.
REQ-024 When BLANK_LEADING=0, all three digits SHALL always be decoded.
REQ-025 hold SHALL affect only the bcd load; scanning continues while hold=1.

Reset
REQ-026 While rst_n=0 the following SHALL be held: FSM=IDLE, prescaler=0, index=0, bcd=000, seg=00, dig_en=000, busy=0, shift register and accumulator=0.
REQ-027 Reset assertion SHALL take effect immediately without a clock and SHALL abort any conversion in progress.
REQ-028 At the first edge after release, dig_en SHALL be 001 and the first conversion sample SHALL occur.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the 10-entry segment constant table, the blank pattern (7'h00) and the digit-enable constants.
REQ-030 The BCD-to-segment decode SHALL be one sub-module, digit_to_seg (4-bit in, 7-bit out, combinational), instantiated once after the digit mux.
REQ-031 No other sub-modules SHALL be used.

Verification (SCAN_DIV=4 unless stated)
REQ-032 value=255 held, rst_n released -> bcd=255 after 10 cycles; scan gives dig_en 001/seg 6D, 010/6D, 100/5B, each for 4 cycles.
REQ-033 value=7, BLANK_LEADING=1 -> ones seg 07, tens 00, hundreds 00; with BLANK_LEADING=0 -> tens 3F, hundreds 3F.
REQ-034 value=0 -> bcd=000; ones seg 3F; tens and hundreds 00.
REQ-035 value=100 sampled, then changed to 42 mid-SHIFT -> bcd=100; next period bcd=042; busy pattern 0,1x9 repeating.
REQ-036 hold=1 with bcd=123, then value=200 -> bcd stays 123 and scanning continues; hold=0 -> bcd=200 within 10 cycles.
REQ-037 rst_n pulsed low mid-SHIFT and mid-scan -> all outputs 0 asynchronously; after release dig_en=001 at the first edge and bcd valid 10 cycles later.
